permute_dump_control: RTL

- FSM that sequences permute_dump_datapath through one SHAKE job: capture job config, absorb rate blocks, run 24 Keccak rounds per block, load the PISO output buffer and stream w-bit words downstream under valid/ready.
- Sits between the input/padding stage (block source) and the output consumer.
- Drives every control input of the datapath and consumes its status outputs.

---
 rtl/permute_dump_control_if.sv | 46 ++++
 rtl/permute_dump_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/permute_dump_control_if.sv
// Handshake and datapath-control bundle for permute_dump_control.
// slave is the controller's view; master is the surrounding datapath/source/sink view.
interface permute_dump_control_if;
    logic start_valid;
    logic start_ready;
    logic blk_valid;
    logic blk_last;
    logic blk_ready;
    logic round_done;
    logic output_buffer_empty;
    logic last_output_block;
    logic output_size_reached;
    logic copy_control_regs_en;
    logic absorb_enable;
    logic round_en;
    logic round_count_load;
    logic state_reset;
    logic output_buffer_we;
    logic output_buffer_shift_en;
    logic output_counter_load;
    logic output_counter_rst;
    logic last_output_block_dump;
    logic out_valid;
    logic out_last;
    logic out_ready;
    logic done;
    logic err;

    modport slave (
        input  start_valid, blk_valid, blk_last, round_done, output_buffer_empty,
               last_output_block, output_size_reached, out_ready,
        output start_ready, blk_ready, copy_control_regs_en, absorb_enable, round_en,
               round_count_load, state_reset, output_buffer_we, output_buffer_shift_en,
               output_counter_load, output_counter_rst, last_output_block_dump,
               out_valid, out_last, done, err
    );

    modport master (
        output start_valid, blk_valid, blk_last, round_done, output_buffer_empty,
               last_output_block, output_size_reached, out_ready,
        input  start_ready, blk_ready, copy_control_regs_en, absorb_enable, round_en,
               round_count_load, state_reset, output_buffer_we, output_buffer_shift_en,
               output_counter_load, output_counter_rst, last_output_block_dump,
               out_valid, out_last, done, err
    );
endinterface

// File: rtl/permute_dump_control.sv
// Job sequencer for the SHAKE permute/dump datapath: absorb, 24-round permute, load, stream words.
// Define SQUEEZE_OVERLAP_EN to run the next squeeze permutation while the output buffer drains.
module permute_dump_control #(
    parameter int NUM_ROUNDS = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    permute_dump_control_if.slave        bus
);

    localparam int RW = $clog2(NUM_ROUNDS);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);
    localparam logic [RW-1:0] ONE        = RW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PERMUTE,
        ST_LOAD,
        ST_DUMP,
        ST_SQUEEZE,
        ST_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          dump_last_q, dump_last_d;
    logic          err_q, err_d;
    logic [RW-1:0] shadow_q, shadow_d;
`ifdef SQUEEZE_OVERLAP_EN
    logic          busy_q, busy_d;
`endif

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path infers a latch.
        state_d     = state_q;
        last_d      = last_q;
        dump_last_d = dump_last_q;
        err_d       = err_q;
        shadow_d    = shadow_q;
`ifdef SQUEEZE_OVERLAP_EN
        busy_d      = busy_q;
`endif
        bus.start_ready            = 1'b0;
        bus.blk_ready              = 1'b0;
        bus.copy_control_regs_en   = 1'b0;
        bus.absorb_enable          = 1'b0;
        bus.round_en               = 1'b0;
        bus.round_count_load       = 1'b0;
        bus.state_reset            = 1'b0;
        bus.output_buffer_we       = 1'b0;
        bus.output_buffer_shift_en = 1'b0;
        bus.output_counter_load    = 1'b0;
        bus.output_counter_rst     = 1'b0;
        bus.last_output_block_dump = 1'b0;
        bus.out_valid              = 1'b0;
        bus.out_last               = 1'b0;
        bus.done                   = 1'b0;
        bus.err                    = 1'b0;

        if (!rst) begin
            // Outputs are gated during reset so the datapath sees a quiet, counter-cleared interface.
            bus.output_counter_rst = 1'b1;
        end else begin
            bus.err = err_q;
            case (state_q)
                ST_IDLE: begin
                    bus.start_ready        = 1'b1;
                    bus.output_counter_rst = 1'b1;
                    if (bus.start_valid) begin
                        bus.copy_control_regs_en = 1'b1;
                        bus.state_reset          = 1'b1;
                        bus.round_count_load     = 1'b1;
                        state_d                  = ST_ABSORB;
                    end
                end

                ST_ABSORB: begin
                    bus.blk_ready = 1'b1;
                    if (bus.blk_valid) begin
                        bus.absorb_enable = 1'b1;
                        bus.round_en      = 1'b1;
                        last_d            = bus.blk_last;
                        shadow_d          = ONE;
                        state_d           = ST_PERMUTE;
                    end
                end

                ST_PERMUTE, ST_SQUEEZE: begin
                    bus.round_en = 1'b1;
                    shadow_d     = shadow_q + ONE;
                    if (bus.round_done) begin
                        if (shadow_q != LAST_ROUND) err_d = 1'b1;
`ifdef SQUEEZE_OVERLAP_EN
                        busy_d = 1'b0;
`endif
                        if (state_q == ST_PERMUTE && !last_q) begin
                            bus.round_count_load = 1'b1;
                            state_d              = ST_ABSORB;
                        end else if (bus.output_size_reached) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    bus.output_buffer_we       = 1'b1;
                    bus.output_counter_load    = 1'b1;
                    bus.last_output_block_dump = bus.last_output_block;
                    dump_last_d                = bus.last_output_block;
                    state_d                    = ST_DUMP;
`ifdef SQUEEZE_OVERLAP_EN
                    busy_d = !bus.last_output_block;
                    if (!bus.last_output_block) begin
                        bus.round_count_load = 1'b1;
                        shadow_d             = '0;
                    end
`endif
                end

                ST_DUMP: begin
                    bus.out_valid              = 1'b1;
                    bus.output_buffer_shift_en = bus.out_ready;
                    bus.last_output_block_dump = dump_last_q;
                    bus.out_last               = dump_last_q && bus.output_buffer_empty;
`ifdef SQUEEZE_OVERLAP_EN
                    if (busy_q) begin
                        bus.round_en = 1'b1;
                        shadow_d     = shadow_q + ONE;
                        if (bus.round_done) begin
                            if (shadow_q != LAST_ROUND) err_d = 1'b1;
                            busy_d = 1'b0;
                        end
                    end
                    if (bus.out_ready && bus.output_buffer_empty) begin
                        if (dump_last_q) begin
                            state_d = ST_DONE;
                        end else if (!busy_q || bus.round_done) begin
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_SQUEEZE;
                        end
                    end
`else
                    if (bus.out_ready && bus.output_buffer_empty) begin
                        if (dump_last_q) begin
                            state_d = ST_DONE;
                        end else begin
                            bus.round_count_load = 1'b1;
                            shadow_d             = '0;
                            state_d              = ST_SQUEEZE;
                        end
                    end
`endif
                end

                ST_DONE: begin
                    bus.done = 1'b1;
                    state_d  = ST_IDLE;
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b0;
            dump_last_q <= 1'b0;
            err_q       <= 1'b0;
            shadow_q    <= '0;
`ifdef SQUEEZE_OVERLAP_EN
            busy_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            dump_last_q <= dump_last_d;
            err_q       <= err_d;
            shadow_q    <= shadow_d;
`ifdef SQUEEZE_OVERLAP_EN
            busy_q      <= busy_d;
`endif
        end
    end

endmodule
